// File: rtl/train_sequencer_pkg.sv
// Shared types, defaults and activation helper for the training sequencer.
package train_sequencer_pkg;

  localparam int ARGW_D   = 8;
  localparam int ARGD_D   = 2;
  localparam int RESW_D   = 16;
  localparam int ERRW_D   = 16;
  localparam int FBKW_D   = 16;
  localparam int FBKD_D   = 2;
  localparam int DEPTH_D  = 4;
  localparam int EPOCHS_D = 25;

  localparam logic [RESW_D-1:0] HIGH_D = 16'h00ff;

  typedef enum logic [2:0] {
    IDLE,
    ARG,
    RES,
    ERR,
    FBK,
    CARG,
    CRES,
    DONE
  } state_t;

  // A result fires when its sign bit is clear (non-negative).
  function automatic logic fires(input logic sign);
    return !sign;
  endfunction

endpackage

// File: rtl/sample_table.sv
// Sample store: one synchronous write port, one asynchronous read port.
module sample_table #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/train_sequencer.sv
// Drives an associate through EPOCHS training passes over a sample
// table, then a check pass that counts samples still misclassified.
module train_sequencer
  import train_sequencer_pkg::*;
#(
  parameter int ARGW   = ARGW_D,
  parameter int ARGD   = ARGD_D,
  parameter int RESW   = RESW_D,
  parameter int ERRW   = ERRW_D,
  parameter int FBKW   = FBKW_D,
  parameter int FBKD   = FBKD_D,
  parameter int DEPTH  = DEPTH_D,
  parameter int EPOCHS = EPOCHS_D,
  parameter logic [RESW-1:0] HIGH = HIGH_D
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ARGD*ARGW-1:0]         smp_data,
  input  logic [RESW-1:0]              smp_tgt,
  input  logic                         smp_valid,
  output logic                         smp_ready,
  input  logic                         clr,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [$clog2(DEPTH+1)-1:0]   misses,
  output logic [ARGD*ARGW-1:0]         arg_data,
  output logic                         arg_valid,
  input  logic                         arg_ready,
  input  logic [RESW-1:0]              res_data,
  input  logic                         res_valid,
  output logic                         res_ready,
  output logic [ERRW-1:0]              err_data,
  output logic                         err_valid,
  input  logic                         err_ready,
  input  logic [FBKD*FBKW-1:0]         fbk_data,
  input  logic                         fbk_valid,
  output logic                         fbk_ready,
  output logic                         en
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = (EPOCHS > 1) ? $clog2(EPOCHS) : 1;
  localparam int SW = ARGD * ARGW;
  localparam int TW = SW + RESW;

  state_t          state, state_nx;
  logic [CW-1:0]   count, count_nx;
  logic [AW-1:0]   idx, idx_nx;
  logic [EW-1:0]   epoch, epoch_nx;
  logic [CW-1:0]   miss, miss_nx;
  logic            en_q, en_nx;
  logic [ERRW-1:0] err_q, err_nx;

  logic [TW-1:0]   rd;
  logic [RESW-1:0] tgt;
  logic [RESW-1:0] act;
  logic [ERRW-1:0] err_calc;
  logic            idle;
  logic            last;
  logic            last_ep;
  logic            wr;
  logic            unused_in;

  assign idle    = (state == IDLE) || (state == DONE);
  assign last    = (CW'(idx) == count - 1'b1);
  assign last_ep = (epoch == EW'(EPOCHS - 1));

  // The start cycle commits the table size, so no load may race it.
  assign smp_ready = rst && idle && !start
                   && (count < CW'(DEPTH));
  assign wr = smp_valid && smp_ready && !clr;

  sample_table #(
    .DEPTH (DEPTH),
    .W     (TW),
    .AW    (AW)
  ) u_table (
    .clk   (clk),
    .we    (wr),
    .waddr (AW'(count)),
    .wdata ({smp_data, smp_tgt}),
    .raddr (idx),
    .rdata (rd)
  );

  assign arg_data = rd[TW-1 -: SW];
  assign tgt      = rd[RESW-1:0];
  assign act      = fires(res_data[RESW-1]) ? HIGH : '0;
  assign err_calc = ERRW'(tgt) - ERRW'(act);

  assign unused_in = ^{res_data[RESW-2:0], fbk_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      idx   <= '0;
      epoch <= '0;
      miss  <= '0;
      en_q  <= 1'b0;
      err_q <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      idx   <= idx_nx;
      epoch <= epoch_nx;
      miss  <= miss_nx;
      en_q  <= en_nx;
      err_q <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    idx_nx    = idx;
    epoch_nx  = epoch;
    miss_nx   = miss;
    en_nx     = en_q;
    err_nx    = err_q;
    arg_valid = 1'b0;
    res_ready = 1'b0;
    err_valid = 1'b0;
    fbk_ready = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (clr) begin
          count_nx = '0;
        end else if (wr) begin
          count_nx = count + 1'b1;
        end
        if (start) begin
          miss_nx = '0;
          if (clr || count == '0) begin
            state_nx = DONE;
          end else begin
            state_nx = ARG;
            idx_nx   = '0;
            epoch_nx = '0;
            en_nx    = 1'b1;
          end
        end
      end
      ARG: begin
        arg_valid = 1'b1;
        if (arg_ready) state_nx = RES;
      end
      RES: begin
        res_ready = 1'b1;
        if (res_valid) begin
          err_nx   = err_calc;
          state_nx = ERR;
        end
      end
      ERR: begin
        err_valid = 1'b1;
        if (err_ready) state_nx = FBK;
      end
      FBK: begin
        fbk_ready = 1'b1;
        if (fbk_valid) begin
          if (!last) begin
            idx_nx   = idx + 1'b1;
            state_nx = ARG;
          end else if (!last_ep) begin
            idx_nx   = '0;
            epoch_nx = epoch + 1'b1;
            state_nx = ARG;
          end else begin
            idx_nx   = '0;
            en_nx    = 1'b0;
            miss_nx  = '0;
            state_nx = CARG;
          end
        end
      end
      CARG: begin
        arg_valid = 1'b1;
        if (arg_ready) state_nx = CRES;
      end
      CRES: begin
        res_ready = 1'b1;
        if (res_valid) begin
          if (err_calc != '0) miss_nx = miss + 1'b1;
          if (last) begin
            idx_nx   = '0;
            state_nx = DONE;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = CARG;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy     = !idle;
  assign done     = (state == DONE);
  assign pass     = done && (miss == '0);
  assign misses   = miss;
  assign en       = en_q;
  assign err_data = err_q;

endmodule

// File: tb/tb_train_sequencer.sv
// Bench: perceptron associate, table-driven load checks, randomized runs.
module tb_train_sequencer;
  import train_sequencer_pkg::*;

  localparam int N  = DEPTH_D;
  localparam int EP = EPOCHS_D;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] smp_data = '0;
  logic [15:0] smp_tgt = '0;
  logic        smp_valid = 1'b0;
  logic        smp_ready;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, en;
  logic [2:0]  misses;
  logic [15:0] arg_data;
  logic        arg_valid;
  logic        arg_ready = 1'b0;
  logic [15:0] res_data = '0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [15:0] err_data;
  logic        err_valid;
  logic        err_ready = 1'b0;
  logic [31:0] fbk_data = '0;
  logic        fbk_valid = 1'b0;
  logic        fbk_ready;

  always #5 clk = ~clk;

  train_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .smp_data  (smp_data),
    .smp_tgt   (smp_tgt),
    .smp_valid (smp_valid),
    .smp_ready (smp_ready),
    .clr       (clr),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .misses    (misses),
    .arg_data  (arg_data),
    .arg_valid (arg_valid),
    .arg_ready (arg_ready),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .err_data  (err_data),
    .err_valid (err_valid),
    .err_ready (err_ready),
    .fbk_data  (fbk_data),
    .fbk_valid (fbk_valid),
    .fbk_ready (fbk_ready),
    .en        (en)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  logic [15:0] s_arg [N];
  logic [15:0] s_tgt [N];
  int          n = 1;
  int          stall = 0;
  int          run_id = 0;

  function automatic int xb(input logic [7:0] v);
    return (v != 8'h00) ? 1 : 0;
  endfunction

  function automatic logic [15:0] net(input int a0, input int a1,
                                      input int bb, input logic [15:0] a);
    return 16'(a0 * xb(a[7:0]) + a1 * xb(a[15:8]) + bb);
  endfunction

  function automatic logic [15:0] act_of(input logic [15:0] r);
    return fires(r[15]) ? HIGH_D : 16'h0000;
  endfunction

  function automatic int sgn(input logic [15:0] e);
    return (e == 16'h0) ? 0 : (e[15] ? -1 : 1);
  endfunction

  // Transaction-level outcome: EP training passes then one check pass.
  function automatic int ref_misses();
    int a0 = 0;
    int a1 = 0;
    int bb = 0;
    int m = 0;
    logic [15:0] e;
    for (int ep = 0; ep < EP; ep++) begin
      for (int i = 0; i < n; i++) begin
        e  = s_tgt[i] - act_of(net(a0, a1, bb, s_arg[i]));
        a0 += sgn(e) * xb(s_arg[i][7:0]);
        a1 += sgn(e) * xb(s_arg[i][15:8]);
        bb += sgn(e);
      end
    end
    for (int i = 0; i < n; i++) begin
      if (s_tgt[i] != act_of(net(a0, a1, bb, s_arg[i]))) m++;
    end
    return m;
  endfunction

  // Associate: perceptron with unit learning rate and random stalls.
  int          seen_id = 0;
  int          w0, w1, wb, k;
  int          arg_cnt = 0;
  int          err_cnt = 0;
  int          arg_bad = 0;
  int          err_bad = 0;
  int          stab_bad = 0;
  logic        res_pend = 0, fbk_pend = 0, res_go = 0, fbk_go = 0;
  logic        arg_wait = 0, err_wait = 0;
  logic [15:0] arg_hold, err_hold, exp_err, cur_arg;

  always @(negedge clk) begin
    if (!rst || run_id != seen_id) begin
      seen_id = run_id;
      w0 = 0; w1 = 0; wb = 0;
      arg_cnt = 0; err_cnt = 0;
      arg_bad = 0; err_bad = 0; stab_bad = 0;
      res_pend = 0; fbk_pend = 0; res_go = 0; fbk_go = 0;
      arg_wait = 0; err_wait = 0;
      arg_ready = 0; err_ready = 0;
      res_valid = 0; fbk_valid = 0;
    end else begin
      if (arg_wait && (!arg_valid || arg_data != arg_hold)) stab_bad++;
      if (err_wait && (!err_valid || err_data != err_hold)) stab_bad++;
      if (res_go) begin
        res_valid = 0;
        res_pend = 0;
      end
      if (fbk_go) fbk_valid = 0;
      arg_ready = ($urandom_range(99) >= stall);
      err_ready = ($urandom_range(99) >= stall);
      if (res_pend && !res_valid && $urandom_range(99) >= stall)
        res_valid = 1;
      if (fbk_pend && !fbk_valid && $urandom_range(99) >= stall) begin
        fbk_valid = 1;
        fbk_data = $urandom;
      end
      res_go = res_valid && res_ready;
      fbk_go = fbk_valid && fbk_ready;
      if (fbk_go) fbk_pend = 0;
      arg_wait = arg_valid && !arg_ready;
      arg_hold = arg_data;
      err_wait = err_valid && !err_ready;
      err_hold = err_data;
      if (arg_valid && arg_ready) begin
        k = (n > 0) ? arg_cnt % n : 0;
        if (arg_data != s_arg[k] || en != (arg_cnt < EP * n)) arg_bad++;
        cur_arg = arg_data;
        res_data = net(w0, w1, wb, arg_data);
        exp_err = s_tgt[k] - act_of(res_data);
        res_pend = 1;
        arg_cnt++;
      end
      if (err_valid && err_ready) begin
        if (err_data != exp_err || !en) err_bad++;
        w0 += sgn(err_data) * xb(cur_arg[7:0]);
        w1 += sgn(err_data) * xb(cur_arg[15:8]);
        wb += sgn(err_data);
        err_cnt++;
        fbk_pend = 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic load();
    clr = 1;
    tick();
    clr = 0;
    for (int i = 0; i < n; i++) begin
      smp_valid = 1;
      smp_data = s_arg[i];
      smp_tgt = s_tgt[i];
      tick();
    end
    smp_valid = 0;
  endtask

  task automatic run(input string tag, input int want);
    bit fin;
    fin = 0;
    run_id++;
    tick();
    start = 1;
    tick();
    start = 0;
    #1 check({tag, "_first"}, {busy, arg_valid}, 2'b11);
    for (int c = 0; c < 30000 && !fin; c++) begin
      start = (c == 5);
      tick();
      #1 fin = done;
    end
    start = 0;
    check({tag, "_finish"}, fin, 1);
    check({tag, "_misses"}, misses, want);
    check({tag, "_pass"}, pass, (want == 0));
    check({tag, "_args"}, arg_cnt, (EP + 1) * n);
    check({tag, "_errs"}, err_cnt, EP * n);
    check({tag, "_argbad"}, arg_bad, 0);
    check({tag, "_errbad"}, err_bad, 0);
    check({tag, "_stable"}, stab_bad, 0);
    repeat (3) tick();
    #1 check({tag, "_hold"}, {done, busy, en}, 3'b100);
  endtask

  typedef struct {
    logic sv;
    logic cl;
    logic rdy;
  } vec_t;

  vec_t vt [10];
  bit   fin;

  initial begin
    vt[0] = '{1, 0, 1};
    vt[1] = '{1, 0, 1};
    vt[2] = '{1, 0, 1};
    vt[3] = '{1, 0, 1};
    vt[4] = '{1, 0, 0};
    vt[5] = '{1, 0, 0};
    vt[6] = '{0, 1, 0};
    vt[7] = '{0, 0, 1};
    vt[8] = '{1, 1, 1};
    vt[9] = '{0, 0, 1};

    repeat (3) tick();
    #1 check("rst_init",
      {busy, done, pass, en, misses, arg_valid, res_ready,
       err_valid, fbk_ready, smp_ready}, 12'h0);
    rst = 1;
    tick();
    #1 check("idle_after_rst", {busy, done, pass, smp_ready}, 4'b0001);

    for (int i = 0; i < 10; i++) begin
      smp_valid = vt[i].sv;
      clr = vt[i].cl;
      smp_data = 16'(i * 37);
      smp_tgt = 16'(i);
      #1 check($sformatf("vec%0d_ready", i), smp_ready, vt[i].rdy);
      tick();
    end
    smp_valid = 0;
    clr = 0;

    start = 1;
    tick();
    start = 0;
    #1 check("empty_start", {done, pass, busy, misses, arg_valid},
             7'b1100000);
    repeat (4) tick();
    check("empty_noarg", arg_cnt, 0);

    n = 4;
    s_arg = '{16'h0000, 16'h00ff, 16'hff00, 16'hffff};
    s_tgt = '{16'h0000, 16'h0000, 16'h0000, 16'h00ff};
    load();
    smp_valid = 1;
    smp_data = 16'h1234;
    smp_tgt = 16'h00ff;
    #1 check("fifth_ready", smp_ready, 0);
    tick();
    smp_valid = 0;
    stall = 0;
    run("and", ref_misses());
    check("and_pass", pass, 1);

    s_tgt = '{16'h0000, 16'h00ff, 16'h00ff, 16'h00ff};
    load();
    run("or", ref_misses());
    check("or_pass", pass, 1);
    check("or_misses", misses, 0);

    s_tgt = '{16'h0000, 16'h0000, 16'h0000, 16'h00ff};
    load();
    stall = 50;
    run("and_stall", ref_misses());

    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, N);
      for (int i = 0; i < n; i++) begin
        s_arg[i] = {($urandom_range(1) != 0) ? 8'hff : 8'h00,
                    ($urandom_range(1) != 0) ? 8'hff : 8'h00};
        if ($urandom_range(3) == 0) s_tgt[i] = 16'($urandom);
        else s_tgt[i] = ($urandom_range(1) != 0) ? HIGH_D : 16'h0;
      end
      stall = $urandom_range(10, 60);
      load();
      run($sformatf("rnd%0d", t), ref_misses());
    end

    n = 4;
    s_arg = '{16'h0000, 16'h00ff, 16'hff00, 16'hffff};
    s_tgt = '{16'h0000, 16'h0000, 16'h0000, 16'h00ff};
    load();
    stall = 30;
    run_id++;
    tick();
    start = 1;
    tick();
    start = 0;
    fin = 0;
    for (int c = 0; c < 20000 && !fin; c++) begin
      tick();
      fin = (err_cnt >= 2 * n + 1);
    end
    #1 check("mid_reach", {fin, busy}, 2'b11);
    rst = 0;
    #1 check("mid_rst",
      {busy, done, pass, en, misses, arg_valid, res_ready,
       err_valid, fbk_ready, smp_ready}, 12'h0);
    repeat (2) tick();
    rst = 1;
    tick();
    #1 check("mid_idle", {busy, done, smp_ready}, 3'b001);
    load();
    stall = 20;
    run("rerun", ref_misses());
    check("rerun_pass", pass, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
